// File: rtl/cpu_bus_initiator.sv
// Host-side bus initiator for the cpu core. It turns valid/ready commands into
// CS/write_en write cycles or CS/RD read cycles, then holds each read result on
// a valid/ready response port until it is consumed.
module cpu_bus_initiator #(
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PC_W    = 9,
    parameter int unsigned RD_WAIT = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_read,
    input  logic [INSTR_W-1:0] cmd_instr,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_alu,
    output logic [PC_W-1:0]    rsp_pc,
    output logic               busy,
    output logic               CS,
    output logic               RD,
    output logic               write_en,
    output logic [INSTR_W-1:0] INSTRUCTION,
    output logic [DATA_W-1:0]  INALU,
    input  logic [DATA_W-1:0]  ALURESULT,
    input  logic [PC_W-1:0]    PC
);

    // A zero wait would leave no cycle for RD, so it is treated as one cycle.
    localparam int unsigned RdWaitEff = (RD_WAIT < 1) ? 1 : RD_WAIT;
    localparam int unsigned CntW      = (RdWaitEff > 1) ? $clog2(RdWaitEff) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                cs_q, cs_d;
    logic                rd_q, rd_d;
    logic                we_q, we_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   inalu_q, inalu_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_alu_q, rsp_alu_d;
    logic [PC_W-1:0]     rsp_pc_q, rsp_pc_d;

    // Next-state and next-output decode; strobes are computed for the state being
    // entered so that they appear registered in the same cycle as that state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_d        = 1'b0;
        rd_d        = 1'b0;
        we_d        = 1'b0;
        instr_d     = instr_q;
        inalu_d     = inalu_q;
        rsp_valid_d = 1'b0;
        rsp_alu_d   = rsp_alu_q;
        rsp_pc_d    = rsp_pc_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cs_d = 1'b1;
                    if (cmd_is_read) begin
                        state_d = StRead;
                        cnt_d   = CntW'(RdWaitEff - 1);
                        rd_d    = 1'b1;
                    end else begin
                        state_d = StWrite;
                        instr_d = cmd_instr;
                        inalu_d = cmd_data;
                        we_d    = 1'b1;
                    end
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            StRead: begin
                if (cnt_q == '0) begin
                    state_d     = StResp;
                    rsp_alu_d   = ALURESULT;
                    rsp_pc_d    = PC;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    cs_d  = 1'b1;
                    rd_d  = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            instr_q     <= '0;
            inalu_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_alu_q   <= '0;
            rsp_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            instr_q     <= instr_d;
            inalu_q     <= inalu_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_alu_q   <= rsp_alu_d;
            rsp_pc_q    <= rsp_pc_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign CS          = cs_q;
    assign RD          = rd_q;
    assign write_en    = we_q;
    assign INSTRUCTION = instr_q;
    assign INALU       = inalu_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_alu     = rsp_alu_q;
    assign rsp_pc      = rsp_pc_q;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed bench for cpu_bus_initiator: a negedge monitor checks writes and read
// responses against scoreboard queues filled when commands are driven.
module tb_cpu_bus_initiator;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PC_W    = 9;
    localparam int unsigned RD_WAIT = 2;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_is_read = 1'b0;
    logic [INSTR_W-1:0] cmd_instr = '0;
    logic [DATA_W-1:0]  cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [DATA_W-1:0]  rsp_alu;
    logic [PC_W-1:0]    rsp_pc;
    logic               busy;
    logic               CS;
    logic               RD;
    logic               write_en;
    logic [INSTR_W-1:0] INSTRUCTION;
    logic [DATA_W-1:0]  INALU;
    logic [DATA_W-1:0]  ALURESULT = '0;
    logic [PC_W-1:0]    PC = '0;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int rd_run = 0;

    logic [INSTR_W+DATA_W-1:0] wr_q[$];
    logic [DATA_W+PC_W-1:0]    rsp_q[$];

    cpu_bus_initiator #(
        .INSTR_W(INSTR_W),
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .RD_WAIT(RD_WAIT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_is_read(cmd_is_read),
        .cmd_instr  (cmd_instr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_alu    (rsp_alu),
        .rsp_pc     (rsp_pc),
        .busy       (busy),
        .CS         (CS),
        .RD         (RD),
        .write_en   (write_en),
        .INSTRUCTION(INSTRUCTION),
        .INALU      (INALU),
        .ALURESULT  (ALURESULT),
        .PC         (PC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive point: just after a rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Sample point: falling edge, away from the active edge.
    task automatic smp();
        @(negedge CLK);
    endtask

    // Monitor: write cycles, response handshakes, RD length and strobe exclusivity.
    always @(negedge CLK) begin
        if (!RESET && write_en) begin
            wr_count++;
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'(write_en), 32'd0);
            end else begin
                logic [INSTR_W+DATA_W-1:0] e;
                e = wr_q.pop_front();
                chk("wr_instr", 32'(INSTRUCTION), 32'(e[INSTR_W+DATA_W-1:DATA_W]));
                chk("wr_inalu", 32'(INALU), 32'(e[DATA_W-1:0]));
                chk("wr_cs", 32'(CS), 32'd1);
            end
        end
        if (RD || write_en) chk("rd_we_excl", 32'(RD && write_en), 32'd0);
        if (!RESET && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                logic [DATA_W+PC_W-1:0] r;
                r = rsp_q.pop_front();
                chk("rsp_alu", 32'(rsp_alu), 32'(r[DATA_W+PC_W-1:PC_W]));
                chk("rsp_pc", 32'(rsp_pc), 32'(r[PC_W-1:0]));
                chk("rsp_strobes", 32'({CS, RD, write_en}), 32'd0);
            end
        end
        if (RESET) begin
            rd_run = 0;
        end else if (RD) begin
            rd_run++;
        end else if (rd_run != 0) begin
            chk("rd_len", 32'(rd_run), 32'(RD_WAIT));
            rd_run = 0;
        end
    end

    initial begin
        int n;
        int wr0;

        // 1: reset held three cycles
        repeat (3) cyc();
        smp();
        chk("rst_cs", 32'(CS), 32'd0);
        chk("rst_rd", 32'(RD), 32'd0);
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_instr", 32'(INSTRUCTION), 32'd0);
        chk("rst_inalu", 32'(INALU), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_alu", 32'(rsp_alu), 32'd0);
        chk("rst_rsp_pc", 32'(rsp_pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        cyc();
        RESET = 1'b0;

        // 2: single write
        cyc();
        cmd_valid = 1'b1; cmd_is_read = 1'b0; cmd_instr = 9'h1A5; cmd_data = 8'h3C;
        wr_q.push_back({9'h1A5, 8'h3C});
        smp();
        chk("w_ready_idle", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        smp();
        chk("w_we", 32'(write_en), 32'd1);
        chk("w_rd", 32'(RD), 32'd0);
        chk("w_busy", 32'(busy), 32'd1);
        chk("w_ready_busy", 32'(cmd_ready), 32'd0);
        cyc();
        smp();
        chk("w_we_drop", 32'(write_en), 32'd0);
        chk("w_ready_back", 32'(cmd_ready), 32'd1);

        // 3: read with immediate response consumption
        cyc();
        ALURESULT = 8'h7E; PC = 9'h012; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_is_read = 1'b1;
        rsp_q.push_back({8'h7E, 9'h012});
        cyc();
        cmd_valid = 1'b0;
        smp();
        chk("r_rd1", 32'(RD), 32'd1);
        chk("r_cs1", 32'(CS), 32'd1);
        chk("r_rsp_low", 32'(rsp_valid), 32'd0);
        cyc();
        smp();
        chk("r_rd2", 32'(RD), 32'd1);
        cyc();
        smp();
        chk("r_rd_done", 32'(RD), 32'd0);
        chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
        cyc();
        smp();
        chk("r_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("r_idle", 32'(cmd_ready), 32'd1);
        chk("r_q_empty", 32'(rsp_q.size()), 32'd0);

        // 4: response backpressure with a command held pending
        cyc();
        rsp_ready = 1'b0;
        ALURESULT = 8'hA5; PC = 9'h1F3;
        cmd_valid = 1'b1; cmd_is_read = 1'b1;
        rsp_q.push_back({8'hA5, 9'h1F3});
        cyc();
        cmd_is_read = 1'b0; cmd_instr = 9'h0F0; cmd_data = 8'h55;
        wr_q.push_back({9'h0F0, 8'h55});
        n = 0;
        smp();
        while (!rsp_valid && n < 20) begin
            n++;
            smp();
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        cyc();
        ALURESULT = 8'h00; PC = 9'h000;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_alu", 32'(rsp_alu), 32'hA5);
            chk("bp_pc", 32'(rsp_pc), 32'h1F3);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_we", 32'(write_en), 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        smp();
        chk("bp_after_hs", 32'(rsp_valid), 32'd0);
        chk("bp_ready_after", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        smp();
        chk("bp_write_issued", 32'(write_en), 32'd1);
        cyc();

        // 5: back-to-back writes with cmd_valid held high
        wr0 = wr_count;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_is_read = 1'b0;
            cmd_instr = INSTR_W'(9'h101 + 9'(i * 37));
            cmd_data  = DATA_W'(8'h10 + 8'(i * 3));
            wr_q.push_back({cmd_instr, cmd_data});
            smp();
            chk("b2b_ready", 32'(cmd_ready), 32'd1);
            cyc();
            smp();
            chk("b2b_we", 32'(write_en), 32'd1);
            cyc();
        end
        cmd_valid = 1'b0;
        smp();
        chk("b2b_count", 32'(wr_count - wr0), 32'd4);
        chk("b2b_q_empty", 32'(wr_q.size()), 32'd0);

        // 6: reset during a read aborts it
        cyc();
        rsp_ready = 1'b0;
        ALURESULT = 8'h99; PC = 9'h155;
        cmd_valid = 1'b1; cmd_is_read = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        RESET = 1'b1;
        smp();
        chk("abort_rd_before", 32'(RD), 32'd1);
        cyc();
        smp();
        chk("abort_cs", 32'(CS), 32'd0);
        chk("abort_rd", 32'(RD), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            smp();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_no_we", 32'(write_en), 32'd0);
        end
        cyc();
        ALURESULT = 8'h42; PC = 9'h0AB; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_is_read = 1'b1;
        rsp_q.push_back({8'h42, 9'h0AB});
        cyc();
        cmd_valid = 1'b0;
        n = 0;
        smp();
        while (rsp_q.size() != 0 && n < 20) begin
            n++;
            smp();
        end
        chk("post_rst_rsp_done", 32'(rsp_q.size()), 32'd0);
        cyc();
        smp();
        chk("post_rst_idle", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so a stuck design still terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
